// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin arbiter driving a shared 8:1 mux.
// Each holder keeps the mux for at most HOLD cycles, then yields.
module mux8_rr_sched #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       y_q, y_d;
    logic       y_valid_q, y_valid_d;

    logic [2:0] rel_ptr;
    logic [3:0] win_idle;
    logic [3:0] win_rel;

    // Returns {found, index}: first set request scanning start..start+7.
    function automatic logic [3:0] pick(input logic [7:0] r,
                                        input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Next-state, arbitration and mux sampling.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        rel_ptr   = sel_q + 3'd1;
        win_idle  = pick(req, ptr_q);
        win_rel   = pick(req, rel_ptr);
        unique case (state_q)
            IDLE: begin
                if (win_idle[3]) begin
                    sel_d   = win_idle[2:0];
                    gnt_d   = 8'b1 << win_idle[2:0];
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (req[sel_q]) begin
                    y_d       = d[sel_q];
                    y_valid_d = 1'b1;
                end
                if (!req[sel_q] || cnt_q == HOLD_M1) begin
                    // Holder rotates to lowest priority; regrant without bubble.
                    ptr_d = rel_ptr;
                    if (win_rel[3]) begin
                        sel_d = win_rel[2:0];
                        gnt_d = 8'b1 << win_rel[2:0];
                        cnt_d = 4'd0;
                    end else begin
                        gnt_d   = 8'd0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= 4'd0;
            sel_q     <= 3'd0;
            gnt_q     <= 8'd0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched: directed and random checks of mux8_rr_sched
// against a behavioural round-robin model.
module tb_mux8_rr_sched;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] d   = 8'd0;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       y;
    logic       y_valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit m_busy;
    int m_sel, m_cnt, m_ptr;
    bit m_y, m_yv;

    mux8_rr_sched #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .d(d),
        .sel(sel), .gnt(gnt), .y(y), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_sel = 0; m_cnt = 0; m_ptr = 0; m_y = 0; m_yv = 0;
    endfunction

    function automatic void model_edge(input logic [7:0] r,
                                       input logic [7:0] dd);
        int w;
        if (!m_busy) begin
            m_yv = 0;
            w = winner(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_cnt = 0;
            end
        end else begin
            bit rel;
            rel = !r[m_sel] || (m_cnt == HOLD - 1);
            if (r[m_sel]) begin
                m_y = dd[m_sel]; m_yv = 1;
            end else begin
                m_yv = 0;
            end
            if (rel) begin
                m_ptr = (m_sel + 1) % 8;
                w = winner(r, m_ptr);
                if (w >= 0) begin
                    m_sel = w; m_cnt = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] eg;
        eg = m_busy ? (8'd1 << m_sel) : 8'd0;
        cmp({tag, ".gnt"}, gnt, eg);
        cmp({tag, ".sel"}, {5'd0, sel}, 8'(m_sel));
        cmp({tag, ".y"}, {7'd0, y}, {7'd0, m_y});
        cmp({tag, ".y_valid"}, {7'd0, y_valid}, {7'd0, m_yv});
        cmp({tag, ".busy"}, {7'd0, busy}, {7'd0, m_busy});
    endtask

    task automatic step(input string tag, input logic [7:0] r,
                        input logic [7:0] dd);
        req = r;
        d   = dd;
        @(posedge clk);
        model_edge(r, dd);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b0;
    endtask

    logic [7:0] r_rand, d_rand;
    logic       prev_d7;

    initial begin
        model_reset();
        #2;
        check_all("reset_async");
        do_reset();

        // single requester with periodic regrant
        for (int i = 0; i < 13; i++) begin
            step("single", 8'h04, 8'h04);
            if (i == 0) begin
                cmp("single.first_gnt", gnt, 8'h04);
                cmp("single.first_yv", {7'd0, y_valid}, 8'd0);
            end
            if (i >= 1) cmp("single.yv", {7'd0, y_valid}, 8'd1);
        end

        // all requesting: grant order rotates every HOLD cycles
        do_reset();
        for (int i = 0; i < 9 * HOLD; i++) begin
            step("all", 8'hFF, 8'(i * 37));
            cmp("all.sel_order", {5'd0, sel}, 8'((i / HOLD) % 8));
        end

        // early release of index 3 while index 5 waits
        do_reset();
        step("early.g", 8'h28, 8'hFF);
        cmp("early.gnt3", gnt, 8'h08);
        step("early.h1", 8'h28, 8'hFF);
        step("early.h2", 8'h28, 8'hFF);
        step("early.drop", 8'h20, 8'hFF);
        cmp("early.gnt5", gnt, 8'h20);
        cmp("early.yv0", {7'd0, y_valid}, 8'd0);

        // ptr=6 after index 5 drops: scan wraps to 0 then 1
        step("skip.h", 8'h20, 8'hFF);
        step("skip.drop", 8'h03, 8'hFF);
        cmp("skip.gnt0", gnt, 8'h01);
        for (int i = 0; i < HOLD; i++) step("skip.hold", 8'h03, 8'hFF);
        cmp("skip.gnt1", gnt, 8'h02);

        // async reset during grant to index 4
        do_reset();
        step("ar.g", 8'h10, 8'h10);
        step("ar.v", 8'h10, 8'h10);
        cmp("ar.pre_yv", {7'd0, y_valid}, 8'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        cmp("ar.gnt_now", gnt, 8'h00);
        cmp("ar.yv_now", {7'd0, y_valid}, 8'd0);
        check_all("ar.now");
        #1 rst = 1'b0;
        step("ar.regrant", 8'h10, 8'h10);
        cmp("ar.gnt4", gnt, 8'h10);

        // data tracking on index 7
        do_reset();
        prev_d7 = 1'b0;
        step("dt.g", 8'h80, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step("dt", 8'h80, {prev_d7 ^ 1'b1, 7'd0});
            prev_d7 = prev_d7 ^ 1'b1;
            cmp("dt.y", {7'd0, y}, {7'd0, prev_d7});
            cmp("dt.yv", {7'd0, y_valid}, 8'd1);
        end

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r_rand = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r_rand = r_rand & 8'($urandom);
            if ($urandom_range(0, 9) == 0) r_rand = 8'd0;
            d_rand = 8'($urandom);
            step("rand", r_rand, d_rand);
            n_tests++;
            assert ($countones(gnt) <= 1 && !(gnt == 8'd0 && y_valid))
            else begin
                n_fail++;
                $error("FAIL rand.onehot: observed gnt=%h yv=%b expected onehot/idle-invalid",
                       gnt, y_valid);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux8_rr_sched.md
MUX8_RR_SCHED -- requirements
Module: mux8_rr_sched

Interface
REQ-001 Parameter: HOLD, default 4, sets the maximum consecutive grant cycles per requester; legal range is 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req  input  8  request lines; req[i] is held high by requester i while it wants the shared 8:1 mux.
REQ-005 Port: d  input  8  mux data inputs; d[i] belongs to requester i.
REQ-006 Port: sel  output  3  registered mux select, equal to the index of the granted requester.
REQ-007 Port: gnt  output  8  registered one-hot grant, or all zeros when idle.
REQ-008 Port: y  output  1  registered mux output, equal to d[sel] as sampled.
REQ-009 Port: y_valid  output  1  registered; y carries a valid sample this cycle.
REQ-010 Port: busy  output  1  high while the state is GRANT.

Function
REQ-011 The block shall have 2 states: IDLE (gnt=0) and GRANT (gnt=onehot(sel)).
REQ-012 The block shall hold internal registers: ptr[2:0] (round-robin start index) and cnt[3:0] (grant-cycle counter).
REQ-013 Winner selection shall be the first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7, all mod 8.
REQ-014 IDLE, req≠0 at an edge: the block shall set sel<=winner, gnt<=onehot(winner), cnt<=0, and state<=GRANT.
REQ-015 IDLE, req=0: the block shall remain in IDLE with all outputs holding their idle values.
REQ-016 GRANT, at each edge: if req[sel]=1, the block shall load y<=d[sel] and y_valid<=1; otherwise it shall set y_valid<=0 and y holds its value.
REQ-017 Release condition in GRANT: req[sel]=0 or cnt=HOLD-1.
REQ-018 GRANT without release: the block shall increment cnt and leave sel and gnt unchanged.
REQ-019 GRANT with release: the block shall set ptr<=sel+1 mod 8 and recompute the winner using the new ptr value in the same cycle.
REQ-020 On release, if a winner exists, the block shall grant it at the same edge (no idle bubble) with cnt<=0.
REQ-021 On release, if no winner exists, the block shall set gnt<=0 and state<=IDLE.
REQ-022 The current holder shall have lowest priority on release; when it is the only requester it shall be re-granted immediately and cnt restarts.
REQ-023 Wrap-around: index 7 is followed by index 0; ptr+1 from 7 shall be 0.
REQ-024 A requester deasserting req before being granted shall simply be skipped; there is no queueing.
REQ-025 gnt shall never have more than one bit set.
REQ-026 y_valid shall be 0 in any cycle where gnt=0.
REQ-027 Latency: a grant shall appear 1 edge after req is sampled, and the first valid y shall appear 1 edge after the grant.
REQ-028 busy shall equal (state==GRANT).

Reset
REQ-029 While rst=1, the block shall immediately force state=IDLE, gnt=0, sel=0, y=0, y_valid=0, busy=0, ptr=0, cnt=0, independent of clk.
REQ-030 Reset asserted mid-grant shall abort the grant; after rst deasserts, arbitration shall restart from ptr=0.

Verification
REQ-031 Single requester: req=8'b0000_0100, d=8'b0000_0100, HOLD=4 -> gnt=8'b0000_0100, sel=3'b010 after 1 edge; y=1, y_valid=1 from the 2nd edge; re-grant to index 2 every 4 cycles with no gap.
REQ-032 All requesting: req=8'hFF from reset -> grant order 0,1,2,...,7,0, each held for 4 cycles, with sel stepping 3'b000..3'b111 and then wrapping to 3'b000.
REQ-033 Early release: req[3] dropped after 2 grant cycles while req[5]=1 -> gnt moves to 8'b0010_0000 at the same edge, and y_valid=0 in the drop cycle.
REQ-034 Skip: ptr=6 and req=8'b0000_0011 -> winner is index 0, then index 1, with the scan wrapping across 7->0.
REQ-035 Async reset: rst pulsed between clock edges during a grant to index 4 -> gnt=0 and y_valid=0 immediately; with req=8'h10 held, index 4 is re-granted 1 edge after rst falls.
REQ-036 Data tracking: hold a grant to index 7 and toggle d[7] each cycle -> y follows d[7] delayed by one cycle, and y_valid=1 throughout the grant.
